// File: rtl/spi_byte_queue.sv
// Bus front end for the byte-wide SPI shift engine: a TX byte FIFO feeds the engine
// through a start/done handshake, and received bytes are collected in an RX FIFO.
module spi_byte_queue #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   output logic        ready,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        eng_start,
   output logic [7:0]  eng_txd,
   input  logic        eng_done,
   input  logic [7:0]  eng_rxd,
   output logic        irq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            ready_q, ready_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [AW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [AW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic            txovf_q, txovf_d, rxovf_q, rxovf_d;
   logic            ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d;

   logic [7:0]      tx_mem_q [DEPTH];
   logic [7:0]      rx_mem_q [DEPTH];

   logic            acc, is_wr;
   logic [1:0]      sel;
   logic            data_wr, data_rd, stat_wr, ctrl_wr, flush;
   logic            tx_empty, tx_full, rx_empty, rx_full, busy;
   logic            tx_push, tx_pop, rx_push, rx_push_req, rx_pop;
   logic [AW-1:0]   rx_wr_addr;
   logic [7:0]      tx_head, rx_head;
   logic            unused_bits;

   assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8]};

   // Counts are CW bits wide; the status register shows them in 8 bits, clamped.
   function automatic logic [7:0] cnt8(input logic [CW-1:0] c);
      logic [8:0] w;
      w = 9'(c);
      return (w > 9'd255) ? 8'hFF : w[7:0];
   endfunction

   always_comb begin
      acc      = valid & ~ready_q;
      is_wr    = |wstrb;
      sel      = addr[3:2];
      data_wr  = acc & is_wr  & (sel == 2'd0);
      data_rd  = acc & ~is_wr & (sel == 2'd0);
      stat_wr  = acc & is_wr  & (sel == 2'd1);
      ctrl_wr  = acc & is_wr  & (sel == 2'd2);
      flush    = ctrl_wr & wdata[2];

      tx_empty = (tx_cnt_q == '0);
      tx_full  = (tx_cnt_q == CW'(DEPTH));
      rx_empty = (rx_cnt_q == '0);
      rx_full  = (rx_cnt_q == CW'(DEPTH));
      busy     = (state_q == BUSY);
      tx_head  = tx_mem_q[tx_rptr_q];
      rx_head  = rx_mem_q[rx_rptr_q];

      state_d     = state_q;
      tx_pop      = 1'b0;
      rx_push_req = 1'b0;
      unique case (state_q)
         IDLE: if (!tx_empty) begin
            tx_pop  = 1'b1;
            state_d = BUSY;
         end
         BUSY: if (eng_done) begin
            rx_push_req = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      eng_start = tx_pop;
      eng_txd   = tx_pop ? tx_head : 8'h00;

      // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
      tx_push = data_wr & (~tx_full | tx_pop);
      rx_pop  = data_rd & ~rx_empty;
      rx_push = rx_push_req & (~rx_full | rx_pop);

      if (flush) begin
         tx_wptr_d = '0;
         tx_rptr_d = '0;
         tx_cnt_d  = '0;
      end else begin
         tx_wptr_d = tx_wptr_q + AW'(tx_push);
         tx_rptr_d = tx_rptr_q + AW'(tx_pop);
         tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      end

      // A byte finishing during a flush is stored at the head of the emptied RX FIFO.
      rx_wr_addr = flush ? '0 : rx_wptr_q;
      rx_wptr_d  = rx_wr_addr + AW'(rx_push);
      rx_rptr_d  = flush ? '0 : rx_rptr_q + AW'(rx_pop);
      rx_cnt_d   = flush ? CW'(rx_push) : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

      txovf_d = txovf_q;
      rxovf_d = rxovf_q;
      if (stat_wr && wdata[2]) txovf_d = 1'b0;
      if (stat_wr && wdata[3]) rxovf_d = 1'b0;
      if (data_wr && tx_full && !tx_pop) txovf_d = 1'b1;
      if (rx_push_req && rx_full && !rx_pop) rxovf_d = 1'b1;

      ie_rx_d = ie_rx_q;
      ie_tx_d = ie_tx_q;
      if (ctrl_wr) begin
         ie_rx_d = wdata[0];
         ie_tx_d = wdata[1];
      end

      ready_d = acc;
      rdata_d = 32'h0;
      if (acc && !is_wr) begin
         case (sel)
            2'd0: rdata_d = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_head};
            2'd1: rdata_d = {8'b0, cnt8(rx_cnt_q), cnt8(tx_cnt_q), 4'b0,
                             rxovf_q, txovf_q, busy, tx_empty};
            2'd2: rdata_d = {30'b0, ie_tx_q, ie_rx_q};
            default: rdata_d = 32'h0;
         endcase
      end

      irq = (~rx_empty & ie_rx_q) | (tx_empty & ~busy & ie_tx_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
         txovf_q   <= 1'b0;
         rxovf_q   <= 1'b0;
         ie_rx_q   <= 1'b0;
         ie_tx_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         tx_wptr_q <= tx_wptr_d;
         tx_rptr_q <= tx_rptr_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_wptr_q <= rx_wptr_d;
         rx_rptr_q <= rx_rptr_d;
         rx_cnt_q  <= rx_cnt_d;
         txovf_q   <= txovf_d;
         rxovf_q   <= rxovf_d;
         ie_rx_q   <= ie_rx_d;
         ie_tx_q   <= ie_tx_d;
      end
   end

   // Storage needs no reset; the pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wptr_q] <= wdata[7:0];
      if (rx_push) rx_mem_q[rx_wr_addr] <= eng_rxd;
   end

   assign ready = ready_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_byte_queue.sv
// Directed self-checking bench for spi_byte_queue with a hand-driven engine model.
module tb_spi_byte_queue;

   localparam int DEPTH = 16;
   localparam logic [31:0] A_DATA = 32'h0;
   localparam logic [31:0] A_STAT = 32'h4;
   localparam logic [31:0] A_CTRL = 32'h8;
   localparam logic [31:0] A_RSVD = 32'hC;

   logic        clk = 1'b0;
   logic        reset, valid, ready;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  wstrb;
   logic        eng_start, eng_done, irq;
   logic [7:0]  eng_txd, eng_rxd;

   int checks = 0;
   int failures = 0;

   spi_byte_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr),
      .wstrb(wstrb), .wdata(wdata), .rdata(rdata), .eng_start(eng_start),
      .eng_txd(eng_txd), .eng_done(eng_done), .eng_rxd(eng_rxd), .irq(irq)
   );

   always #5 clk = ~clk;

   // All bench activity happens 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] r);
      bit got;
      got = 1'b0;
      r = 32'h0;
      addr = a; wstrb = s; wdata = d; valid = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (ready) begin
            r = rdata;
            got = 1'b1;
         end
      end
      valid = 1'b0; wstrb = 4'h0;
      if (!got) begin
         checks++; failures++;
         $display("[TB] FAIL bus_timeout addr=%h got ready=0 want ready=1", a);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus_xfer(a, 4'hF, d, dummy);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
      bus_xfer(a, 4'h0, 32'h0, r);
   endtask

   task automatic pulse_done(input logic [7:0] b);
      eng_rxd = b;
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
   endtask

   task automatic wait_start(output logic [7:0] t, output bit ok);
      ok = 1'b0;
      t = 8'h00;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (eng_start) begin
            t = eng_txd;
            ok = 1'b1;
         end else begin
            step();
         end
      end
   endtask

   task automatic apply_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      checks++;
      if ({ready, rdata, eng_start, eng_txd, irq} !== 43'h0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%h want=0", {ready, rdata, eng_start, eng_txd, irq});
      end
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("[TB] FAIL reset_stat got=%h want=%h", r, 32'h1); end
      bus_read(A_DATA, r);
      checks++; if (r !== 32'h0) begin failures++; $display("[TB] FAIL empty_data_read got=%h want=0", r); end
      bus_write(A_RSVD, 32'hFFFF_FFFF);
      bus_read(A_RSVD, r);
      checks++; if (r !== 32'h0) begin failures++; $display("[TB] FAIL reserved_read got=%h want=0", r); end
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("[TB] FAIL reset_stat_noflags got=%h want=%h", r, 32'h1); end
   endtask

   task automatic test_two_bytes();
      logic [31:0] r;
      logic [7:0]  t;
      bit ok;
      int starts;
      bus_write(A_DATA, 32'hA5);
      wait_start(t, ok);
      checks++; if (!ok || t !== 8'hA5) begin failures++; $display("[TB] FAIL first_start txd=%h ok=%0d want A5", t, ok); end
      bus_write(A_DATA, 32'h3C);
      starts = 0;
      repeat (4) begin
         if (eng_start) starts++;
         step();
      end
      checks++; if (starts != 0) begin failures++; $display("[TB] FAIL start_while_busy got=%0d want=0", starts); end
      pulse_done(8'h5A);
      checks++;
      if (eng_start !== 1'b1 || eng_txd !== 8'h3C) begin
         failures++;
         $display("[TB] FAIL second_start start=%b txd=%h want 1/3C", eng_start, eng_txd);
      end
      step();
      pulse_done(8'hC3);
      bus_read(A_DATA, r);
      checks++; if (r !== 32'h15A) begin failures++; $display("[TB] FAIL rx_first got=%h want=%h", r, 32'h15A); end
      bus_read(A_DATA, r);
      checks++; if (r !== 32'h1C3) begin failures++; $display("[TB] FAIL rx_second got=%h want=%h", r, 32'h1C3); end
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("[TB] FAIL stat_after_pair got=%h want=%h", r, 32'h1); end
   endtask

   task automatic test_tx_overflow();
      logic [31:0] r;
      logic [7:0]  t;
      bit ok;
      bus_write(A_DATA, 32'h10);
      wait_start(t, ok);
      checks++; if (!ok || t !== 8'h10) begin failures++; $display("[TB] FAIL ovf_first_start txd=%h ok=%0d want 10", t, ok); end
      for (int i = 1; i < DEPTH + 2; i++) bus_write(A_DATA, 32'h10 + 32'(i));
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h0000_1006) begin failures++; $display("[TB] FAIL tx_full_stat got=%h want=%h", r, 32'h0000_1006); end
      bus_write(A_STAT, 32'h4);
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h0000_1002) begin failures++; $display("[TB] FAIL txovf_clear got=%h want=%h", r, 32'h0000_1002); end
   endtask

   task automatic test_rx_overflow();
      logic [31:0] r;
      int bad;
      bad = 0;
      for (int i = 0; i <= DEPTH; i++) begin
         pulse_done(8'hB0 + 8'(i));
         if (i < DEPTH) begin
            if (eng_start !== 1'b1 || eng_txd !== 8'h11 + 8'(i)) bad++;
         end else if (eng_start !== 1'b0) begin
            bad++;
         end
         step();
      end
      checks++; if (bad != 0) begin failures++; $display("[TB] FAIL drain_txd_seq got=%0d bad want=0", bad); end
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h0010_0009) begin failures++; $display("[TB] FAIL rx_full_stat got=%h want=%h", r, 32'h0010_0009); end
      bus_read(A_DATA, r);
      checks++; if (r !== 32'h1B0) begin failures++; $display("[TB] FAIL rx_oldest got=%h want=%h", r, 32'h1B0); end
      bus_read(A_DATA, r);
      checks++; if (r !== 32'h1B1) begin failures++; $display("[TB] FAIL rx_next got=%h want=%h", r, 32'h1B1); end
      bus_write(A_STAT, 32'h8);
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h000E_0001) begin failures++; $display("[TB] FAIL rxovf_clear got=%h want=%h", r, 32'h000E_0001); end
   endtask

   task automatic test_irq_flush();
      logic [31:0] r;
      logic [7:0]  t;
      bit ok;
      bus_write(A_CTRL, 32'h4);
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("[TB] FAIL flush_idle_stat got=%h want=%h", r, 32'h1); end
      bus_write(A_CTRL, 32'h1);
      bus_read(A_CTRL, r);
      checks++; if (r !== 32'h1) begin failures++; $display("[TB] FAIL ctrl_readback got=%h want=%h", r, 32'h1); end
      bus_write(A_DATA, 32'h77);
      wait_start(t, ok);
      bus_write(A_DATA, 32'h78);
      checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_before_push got=%b want=0", irq); end
      pulse_done(8'h88);
      checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_rise got=%b want=1", irq); end
      step();
      pulse_done(8'h89);
      bus_read(A_DATA, r);
      checks++;
      if (r !== 32'h188 || irq !== 1'b1) begin
         failures++;
         $display("[TB] FAIL irq_hold data=%h irq=%b want 188/1", r, irq);
      end
      bus_read(A_DATA, r);
      checks++;
      if (r !== 32'h189 || irq !== 1'b0) begin
         failures++;
         $display("[TB] FAIL irq_fall data=%h irq=%b want 189/0", r, irq);
      end
      bus_write(A_DATA, 32'h01);
      bus_write(A_DATA, 32'h02);
      bus_write(A_DATA, 32'h03);
      pulse_done(8'h44);
      step();
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h0001_0102) begin failures++; $display("[TB] FAIL pre_flush_stat got=%h want=%h", r, 32'h0001_0102); end
      bus_write(A_CTRL, 32'h5);
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h0000_0003) begin failures++; $display("[TB] FAIL flush_busy_stat got=%h want=%h", r, 32'h3); end
      bus_read(A_CTRL, r);
      checks++; if (r !== 32'h1) begin failures++; $display("[TB] FAIL flush_selfclear got=%h want=%h", r, 32'h1); end
      pulse_done(8'h55);
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h0001_0001) begin failures++; $display("[TB] FAIL inflight_stored got=%h want=%h", r, 32'h0001_0001); end
      bus_read(A_DATA, r);
      checks++; if (r !== 32'h155) begin failures++; $display("[TB] FAIL inflight_byte got=%h want=%h", r, 32'h155); end
      bus_write(A_CTRL, 32'h2);
      checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_tx_idle got=%b want=1", irq); end
   endtask

   task automatic test_reset_busy();
      logic [31:0] r;
      logic [7:0]  t;
      bit ok;
      bus_write(A_DATA, 32'h99);
      wait_start(t, ok);
      bus_write(A_DATA, 32'h9A);
      apply_reset(1);
      checks++;
      if (eng_start !== 1'b0 || irq !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_busy_outputs start=%b irq=%b want 0/0", eng_start, irq);
      end
      pulse_done(8'h11);
      bus_read(A_STAT, r);
      checks++; if (r !== 32'h1) begin failures++; $display("[TB] FAIL reset_busy_stat got=%h want=%h", r, 32'h1); end
      bus_read(A_DATA, r);
      checks++; if (r !== 32'h0) begin failures++; $display("[TB] FAIL reset_busy_data got=%h want=0", r); end
   endtask

   initial begin
      valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
      eng_done = 1'b0; eng_rxd = '0;
      #1;
      apply_reset(3);
      test_reset();
      test_two_bytes();
      test_tx_overflow();
      test_rx_overflow();
      test_irq_flush();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
